// File: rtl/sb_pkg.sv
// Shared simplebus definitions.
// Used by both the receive and transmit sides of the line.
package sb_pkg;

  typedef enum logic [1:0] {
    SB_RX_IDLE,
    SB_RX_DATA,
    SB_RX_STOP
  } sb_rx_state_t;

  localparam logic SB_IDLE_LEVEL  = 1'b0;
  localparam logic SB_START_LEVEL = 1'b1;
  localparam logic SB_STOP_LEVEL  = 1'b0;

endpackage

// File: rtl/sb_sync.sv
// Line synchroniser: a chain of STAGES flops.
// With STAGES=0 the input passes straight through.
module sb_sync #(
  parameter int STAGES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = clk ^ rst_n;
      assign q = d;
    end else begin : g_ff
      logic [STAGES-1:0] ff;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ff <= '0;
        end else begin
          ff[0] <= d;
          for (int i = 1; i < STAGES; i++) begin
            ff[i] <= ff[i-1];
          end
        end
      end
      assign q = ff[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/sb_line_deser.sv
// Simplebus receive deserialiser: framer, shift register
// and one-deep holding register with error flags.
module sb_line_deser
  import sb_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             line_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overflow,
  input  logic             err_clr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             s;
  sb_rx_state_t     state_q;
  sb_rx_state_t     next_state;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ferr_q;
  logic             ovf_q;
  logic             complete;
  logic             bad_stop;
  logic             drain;

  sb_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (line_in),
    .q    (s)
  );

  always_comb begin
    next_state = state_q;
    complete   = 1'b0;
    bad_stop   = 1'b0;
    unique case (state_q)
      SB_RX_IDLE: begin
        if (s == SB_START_LEVEL) next_state = SB_RX_DATA;
      end
      SB_RX_DATA: begin
        if (count_q == LAST) next_state = SB_RX_STOP;
      end
      SB_RX_STOP: begin
        next_state = SB_RX_IDLE;
        if (s == SB_STOP_LEVEL) complete = 1'b1;
        else                    bad_stop = 1'b1;
      end
      default: next_state = SB_RX_IDLE;
    endcase
  end

  assign drain = valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SB_RX_IDLE;
      count_q <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= next_state;
      ferr_q  <= bad_stop;
      if (state_q == SB_RX_DATA) begin
        shreg_q[count_q] <= s;
        count_q <= count_q + CW'(1);
      end else begin
        count_q <= '0;
      end
      // A completing word may replace one being drained this edge.
      if (complete && (!valid_q || out_ready)) begin
        data_q  <= shreg_q;
        valid_q <= 1'b1;
      end else if (drain) begin
        valid_q <= 1'b0;
      end
      if (complete && valid_q && !out_ready) ovf_q <= 1'b1;
      else if (err_clr)                      ovf_q <= 1'b0;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = (state_q != SB_RX_IDLE);
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_sb_line_deser.sv
// Directed bench for sb_line_deser: an 8-bit direct instance
// and a 16-bit instance with a two-flop synchroniser.
module tb_sb_line_deser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        busy;
  logic        ferr;
  logic        ovf;
  logic        eclr;

  logic        line2;
  logic [15:0] data2;
  logic        valid2;
  logic        ready2;
  logic        busy2;
  logic        ferr2;
  logic        ovf2;
  logic        eclr2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sb_line_deser #(.WIDTH(8), .SYNC_STAGES(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_in  (line),
    .out_data (data),
    .out_valid(valid),
    .out_ready(ready),
    .busy     (busy),
    .frame_err(ferr),
    .overflow (ovf),
    .err_clr  (eclr)
  );

  sb_line_deser #(.WIDTH(16), .SYNC_STAGES(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .line_in  (line2),
    .out_data (data2),
    .out_valid(valid2),
    .out_ready(ready2),
    .busy     (busy2),
    .frame_err(ferr2),
    .overflow (ovf2),
    .err_clr  (eclr2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start, 8 data bits LSB first, stop; ready may be raised on the stop edge.
  task automatic frame8(input logic [7:0] d, input logic stopb,
                        input logic rdy_stop);
    int bc;
    bc = 0;
    line = 1'b1;
    tick();
    if (busy) bc++;
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      tick();
      if (busy) bc++;
    end
    check("busy_cycles", bc, 9);
    line = stopb;
    if (rdy_stop) ready = 1'b1;
    tick();
    ready = 1'b0;
    line = 1'b0;
  endtask

  task automatic frame16(input logic [15:0] d);
    line2 = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      line2 = d[i];
      tick();
    end
    line2 = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    line  = 1'b0;
    ready = 1'b0;
    eclr  = 1'b0;
    line2 = 1'b0;
    ready2 = 1'b0;
    eclr2 = 1'b0;
    tick();
    tick();
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", ferr, 0);
    check("rst_ovf", ovf, 0);
    check("rst_valid2", valid2, 0);
    rst_n = 1'b1;
    tick();
    tick();

    // basic frame
    frame8(8'hA5, 1'b0, 1'b0);
    check("t1_valid", valid, 1);
    check("t1_data", data, 8'hA5);
    check("t1_busy_after", busy, 0);
    check("t1_ferr", ferr, 0);

    // drain, data retained
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("drain_valid", valid, 0);
    check("drain_data", data, 8'hA5);

    // backpressure / overflow
    frame8(8'h3C, 1'b0, 1'b0);
    check("t2_data1", data, 8'h3C);
    check("t2_ovf1", ovf, 0);
    frame8(8'h81, 1'b0, 1'b0);
    check("t2_data2", data, 8'h3C);
    check("t2_ovf2", ovf, 1);
    check("t2_valid", valid, 1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t2_drain", valid, 0);
    check("t2_ovf_sticky", ovf, 1);
    eclr = 1'b1;
    tick();
    eclr = 1'b0;
    check("t2_clr", ovf, 0);

    // completion and handshake on the same edge
    frame8(8'h11, 1'b0, 1'b0);
    check("t3_data1", data, 8'h11);
    frame8(8'h22, 1'b0, 1'b1);
    check("t3_data2", data, 8'h22);
    check("t3_valid", valid, 1);
    check("t3_ovf", ovf, 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("t3_drain", valid, 0);

    // framing error
    frame8(8'hFF, 1'b1, 1'b0);
    check("t4_ferr", ferr, 1);
    check("t4_valid", valid, 0);
    check("t4_busy", busy, 0);
    tick();
    check("t4_ferr_pulse", ferr, 0);
    check("t4_no_start", busy, 0);
    tick();
    check("t4_idle", busy, 0);
    frame8(8'h0F, 1'b0, 1'b0);
    check("t4_next", data, 8'h0F);
    check("t4_next_valid", valid, 1);
    check("t4_next_ferr", ferr, 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    // reset mid-frame
    line = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      line = 1'b0;
      tick();
    end
    check("t5_busy_pre", busy, 1);
    rst_n = 1'b0;
    line = 1'b0;
    tick();
    check("t5_busy", busy, 0);
    check("t5_data", data, 0);
    check("t5_valid", valid, 0);
    check("t5_ferr", ferr, 0);
    check("t5_ovf", ovf, 0);
    rst_n = 1'b1;
    tick();
    frame8(8'h5A, 1'b0, 1'b0);
    check("t5_data2", data, 8'h5A);
    check("t5_valid2", valid, 1);

    // 16-bit with two sync flops: valid two edges after the raw stop
    frame16(16'hBEEF);
    check("t6_valid_0", valid2, 0);
    tick();
    check("t6_valid_1", valid2, 0);
    tick();
    check("t6_valid_2", valid2, 1);
    check("t6_data", data2, 16'hBEEF);

    // overflow set wins over err_clr
    frame16(16'h1234);
    tick();
    eclr2 = 1'b1;
    tick();
    check("t6_ovf_set", ovf2, 1);
    check("t6_data_kept", data2, 16'hBEEF);
    tick();
    eclr2 = 1'b0;
    check("t6_ovf_clr", ovf2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sb_line_deser.md
Name: sb_line_deser

Overview:
- Receive-side stage downstream of the simplebus line buffer: consumes the buffered single-bit line and reassembles framed serial words.
- Parallel words are presented on a valid/ready handshake, with one holding register of buffering.
- Framing errors and overflow are flagged.
- Serves as the consumer that closes the simplebus path in bus-level tests.

Parameters:
WIDTH, 8, data bits per frame; legal range 2..32.
SYNC_STAGES, 0, flops on line_in before the framer; legal range 0..3. 0 means line_in is sampled directly.

Ports:
clk        input   1      clock; all state updates on rising edge
rst_n      input   1      synchronous active-low reset
line_in    input   1      serial line from simplebus buffer output
out_data   output  WIDTH  assembled word (holding register)
out_valid  output  1      holding register full
out_ready  input   1      consumer accepts out_data when out_valid && out_ready
busy       output  1      framer is in DATA or STOP
frame_err  output  1      one-cycle pulse: bad stop bit
overflow   output  1      sticky: word completed while holding full and not drained
err_clr    input   1      clears overflow

Behaviour:
Reset and clocking:
- One clock. Reset is synchronous and active-low, on ports clk / rst_n.
- rst_n low at an edge: state=IDLE, bit counter=0, shift register=0, sync flops=0, out_data=0, out_valid=0, frame_err=0, overflow=0, busy=0.
- Reset mid-frame discards the partial word. No other state survives reset.

Frame format, one bit per clock on the synchronised line s:
- Idle level is 0.
- Start bit is 1.
- WIDTH data bits follow, LSB first.
- Stop bit is 0.

State machine:
- IDLE: s==1 -> DATA, count=0. Otherwise stay in IDLE.
- DATA: shift s into bit[count]; count++. When count==WIDTH-1 -> STOP.
- STOP, s==0: word complete -> IDLE.
- STOP, s==1: frame_err=1 for exactly the next cycle; word discarded; -> IDLE. That 1 is NOT treated as a start bit.
- Back-to-back frames: a start bit may be sampled on the edge immediately after the stop-bit edge (zero idle gap).

Latency:
- Start bit sampled at edge t0 (counted after SYNC_STAGES delay); data bits at t1..tWIDTH; stop bit at tWIDTH+1.
- out_valid and out_data update at edge tWIDTH+1, so they are visible in the following cycle.
- Total latency from a raw line_in start bit = WIDTH+1+SYNC_STAGES edges.

Holding register:
- out_data is stable while out_valid=1.
- Handshake at an edge with no completion: out_valid->0; out_data retains its value.
- Completion while out_valid=0: load the word, out_valid->1.
- Completion and handshake at the same edge: load the new word, out_valid stays 1, no overflow.
- Completion while out_valid=1 and out_ready=0: new word dropped, out_data unchanged, overflow->1.

Overflow flag:
- Sticky until err_clr=1 at an edge.
- If err_clr coincides with a new overflow event, set wins.

busy:
- Combinational decode: state != IDLE.
- Counter width: $clog2(WIDTH).

Decomposition:
- Shared package sb_pkg holds:
  - typedef enum logic [1:0] sb_rx_state_t {SB_RX_IDLE, SB_RX_DATA, SB_RX_STOP};
  - localparam SB_IDLE_LEVEL=1'b0, SB_START_LEVEL=1'b1, SB_STOP_LEVEL=1'b0.
  The transmit-side block reuses these.
- One sub-module, sb_sync: parameterised SYNC_STAGES flop chain, reset to 0, pass-through when SYNC_STAGES=0.
- Framer, shift register and holding register stay in sb_line_deser.

Test Plan (WIDTH=8, SYNC_STAGES=0 unless stated):
1. Basic frame: idle 0; line 1, 1,0,1,0,0,1,0,1, 0 (0xA5) -> out_valid rises in the cycle after the 10th sampled bit, out_data=0xA5; busy high for 9 cycles; frame_err=0.
2. Backpressure: out_ready=0; frames 0x3C then 0x81 back-to-back -> out_data stays 0x3C, overflow=1 after the second stop. Then out_ready=1 for one cycle -> out_valid=0. Then err_clr -> overflow=0.
3. Simultaneous: holding 0x11 valid; raise out_ready on the same edge that samples the stop bit of 0x22 -> out_data=0x22, out_valid stays 1, overflow=0.
4. Framing error: frame 0xFF with stop bit 1, line then 0 -> frame_err one-cycle pulse, no out_valid, state IDLE, no spurious frame from that 1. Next frame 0x0F is received correctly.
5. Reset mid-frame: rst_n=0 for one edge after 4 data bits of 0xF0 -> all outputs 0. Next frame 0x5A -> out_data=0x5A, nothing left over from the aborted frame.
6. Parameters: SYNC_STAGES=2, WIDTH=16, frame 0xBEEF -> out_valid exactly 2 cycles later than the SYNC_STAGES=0 case, out_data=0xBEEF. Overflow with err_clr asserted on the same edge -> overflow=1.
